// File: rtl/cnn_pkg.sv
// -----------------------------------------------------------------------------
// cnn_pkg
// Shared definitions for the CNN pipeline blocks (conv_mac, pooling, ...):
//   - default pixel/weight width and fractional-bit count
//   - coefficient-load state encoding
//   - width-parameterised signed saturation helper
// -----------------------------------------------------------------------------
package cnn_pkg;

  localparam int CNN_DATA_WIDTH = 16;
  localparam int CNN_FRAC_BITS  = 8;

  // Working width of the saturation helper; callers narrow the result.
  localparam int SAT_CALC_WIDTH = 64;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,  // no valid coefficients since reset
    ST_LOAD  = 2'd1,  // coefficients streaming in
    ST_RUN   = 2'd2   // coefficient set complete, windows accepted
  } mac_state_t;

  // Clamp a signed value into the range of a 'width'-bit two's complement
  // number. The result is returned at SAT_CALC_WIDTH and is always
  // representable in 'width' bits, so callers may simply truncate it.
  function automatic logic signed [SAT_CALC_WIDTH-1:0] saturate(
    input logic signed [SAT_CALC_WIDTH-1:0] value,
    input int unsigned                      width
  );
    logic signed [SAT_CALC_WIDTH-1:0] max_v;
    logic signed [SAT_CALC_WIDTH-1:0] min_v;
    max_v = (64'sd1 <<< (width - 1)) - 64'sd1;
    min_v = -(64'sd1 <<< (width - 1));
    if (value > max_v) begin
      return max_v;
    end else if (value < min_v) begin
      return min_v;
    end
    return value;
  endfunction

endpackage

// File: rtl/conv_sat_round.sv
// -----------------------------------------------------------------------------
// conv_sat_round
// Combinational output stage for fixed-point accumulators: round half up at
// the binary point, drop FRAC_BITS fractional bits, saturate to DATA_WIDTH.
// Optional macro CONV_MAC_RELU_EN: negative results are clamped to 0.
//
// Ports:
//   acc_in  [ACC_WIDTH]  signed accumulator, 2*FRAC_BITS fractional bits
//   res_out [DATA_WIDTH] signed result, FRAC_BITS fractional bits
// -----------------------------------------------------------------------------
module conv_sat_round
  import cnn_pkg::*;
#(
  parameter int DATA_WIDTH = CNN_DATA_WIDTH,
  parameter int FRAC_BITS  = CNN_FRAC_BITS,
  parameter int ACC_WIDTH  = 2*CNN_DATA_WIDTH + 5
) (
  input  logic signed [ACC_WIDTH-1:0]  acc_in,
  output logic signed [DATA_WIDTH-1:0] res_out
);

  // Half an output LSB, one bit wider than the accumulator so the rounding
  // add can never wrap.
  localparam logic signed [ACC_WIDTH:0] HALF_LSB =
    {{(ACC_WIDTH-FRAC_BITS+1){1'b0}}, 1'b1, {(FRAC_BITS-1){1'b0}}};

  logic signed [ACC_WIDTH:0]    rounded;
  logic signed [ACC_WIDTH:0]    shifted;
  logic signed [DATA_WIDTH-1:0] sat_res;

  always_comb begin
    rounded = {acc_in[ACC_WIDTH-1], acc_in} + HALF_LSB;
    shifted = rounded >>> FRAC_BITS;
    sat_res = DATA_WIDTH'(saturate(SAT_CALC_WIDTH'(shifted), DATA_WIDTH));
`ifdef CONV_MAC_RELU_EN
    res_out = sat_res[DATA_WIDTH-1] ? '0 : sat_res;
`else
    res_out = sat_res;
`endif
  end

endmodule

// File: rtl/conv_mac.sv
// -----------------------------------------------------------------------------
// conv_mac
// Fixed-point KxK convolution MAC: one output per accepted window,
// sum(w[k]*x[k]) + bias, 3-cycle latency, one window per cycle.
// Weights and bias are loaded serially (weights row-major, then bias).
// Outputs are counted per frame; frame_done marks the last one.
// Optional macro CONV_MAC_RELU_EN: negative results clamp to 0.
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   window_in      NUM_TAPS packed taps, tap i*K+j at [(idx+1)*DW-1 -: DW]
//   window_valid   window_in valid this cycle
//   load_start     pulse: (re)start coefficient load at index 0
//   coef_in        coefficient beat (weights 0..NUM_TAPS-1, then bias)
//   coef_valid     coef_in valid
//   coef_ready     coefficient set complete (RUN)
//   result_out     signed fixed-point result
//   result_valid   result_out valid, one cycle per result
//   frame_done     coincident with the last result of a frame
//   drop_err       sticky: a window arrived while not in RUN
// -----------------------------------------------------------------------------
module conv_mac
  import cnn_pkg::*;
#(
  parameter int DATA_WIDTH  = CNN_DATA_WIDTH,
  parameter int KERNEL_SIZE = 3,
  parameter int FRAC_BITS   = CNN_FRAC_BITS,
  parameter int ACC_WIDTH   = 2*DATA_WIDTH + $clog2(KERNEL_SIZE*KERNEL_SIZE) + 1,
  parameter int IMG_WIDTH   = 32,
  parameter int IMG_HEIGHT  = 32
) (
  input  logic                                         clk,
  input  logic                                         rst_n,
  input  logic [KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0] window_in,
  input  logic                                         window_valid,
  input  logic                                         load_start,
  input  logic [DATA_WIDTH-1:0]                        coef_in,
  input  logic                                         coef_valid,
  output logic                                         coef_ready,
  output logic [DATA_WIDTH-1:0]                        result_out,
  output logic                                         result_valid,
  output logic                                         frame_done,
  output logic                                         drop_err
);

  localparam int NUM_TAPS      = KERNEL_SIZE * KERNEL_SIZE;
  localparam int PROD_WIDTH    = 2 * DATA_WIDTH;
  localparam int CNT_WIDTH     = $clog2(NUM_TAPS + 1);
  localparam int FRAME_LEN     = IMG_WIDTH * IMG_HEIGHT;
  localparam int PIX_CNT_WIDTH = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

  localparam logic [CNT_WIDTH-1:0]     BIAS_BEAT = CNT_WIDTH'(NUM_TAPS);
  localparam logic [PIX_CNT_WIDTH-1:0] LAST_PIX  = PIX_CNT_WIDTH'(FRAME_LEN - 1);

  mac_state_t state_q;
  mac_state_t state_d;
  logic       accept;

  logic [CNT_WIDTH-1:0]         load_cnt_q;
  logic signed [DATA_WIDTH-1:0] weight_q [NUM_TAPS];
  logic signed [DATA_WIDTH-1:0] bias_q;

  // ---------------------------------------------------------------------------
  // Load FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Load FSM: next state. load_start wins over a coefficient beat, so a
  // restart in LOAD never completes on the same cycle.
  // NOTE: every combinational output gets a default first so no path leaves
  // it unassigned (which would infer a latch).
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_EMPTY: if (load_start) state_d = ST_LOAD;
      ST_LOAD: begin
        if (!load_start && coef_valid && load_cnt_q == BIAS_BEAT) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN:   if (load_start) state_d = ST_LOAD;
      default:  state_d = ST_EMPTY;
    endcase
  end

  // Load FSM: outputs. A window arriving with load_start in RUN is still
  // accepted: it is multiplied in S1 before any coefficient is overwritten.
  always_comb begin
    coef_ready = (state_q == ST_RUN);
    accept     = window_valid && coef_ready;
  end

  // ---------------------------------------------------------------------------
  // Coefficient storage
  // ---------------------------------------------------------------------------
  // NOTE: the coefficient array is small and must read as zero after reset,
  // so it is reset like ordinary flops rather than left as uninitialised RAM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_cnt_q <= '0;
      bias_q     <= '0;
      for (int k = 0; k < NUM_TAPS; k++) begin
        weight_q[k] <= '0;
      end
    end else if (load_start) begin
      load_cnt_q <= '0;
    end else if (state_q == ST_LOAD && coef_valid) begin
      if (load_cnt_q == BIAS_BEAT) begin
        bias_q     <= coef_in;
        load_cnt_q <= '0;
      end else begin
        weight_q[load_cnt_q] <= coef_in;
        load_cnt_q           <= load_cnt_q + CNT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_err <= 1'b0;
    end else if (window_valid && !coef_ready) begin
      drop_err <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // S1: per-tap products. The bias travels with the window so results in
  // flight are unaffected by a later reload.
  // ---------------------------------------------------------------------------
  logic signed [DATA_WIDTH-1:0] tap      [NUM_TAPS];
  logic signed [PROD_WIDTH-1:0] prod_q   [NUM_TAPS];
  logic signed [DATA_WIDTH-1:0] bias_s1_q;
  logic                         valid_s1_q;

  always_comb begin
    for (int k = 0; k < NUM_TAPS; k++) begin
      tap[k] = signed'(window_in[k*DATA_WIDTH +: DATA_WIDTH]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_s1_q <= 1'b0;
      bias_s1_q  <= '0;
      for (int k = 0; k < NUM_TAPS; k++) begin
        prod_q[k] <= '0;
      end
    end else begin
      valid_s1_q <= accept;
      if (accept) begin
        bias_s1_q <= bias_q;
        for (int k = 0; k < NUM_TAPS; k++) begin
          prod_q[k] <= PROD_WIDTH'(weight_q[k]) * PROD_WIDTH'(tap[k]);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // S2: adder tree. Bias is aligned to the 2*FRAC_BITS product scale.
  // ---------------------------------------------------------------------------
  logic signed [ACC_WIDTH-1:0] sum_d;
  logic signed [ACC_WIDTH-1:0] acc_q;
  logic                        valid_s2_q;

  always_comb begin
    sum_d = ACC_WIDTH'(bias_s1_q) <<< FRAC_BITS;
    for (int k = 0; k < NUM_TAPS; k++) begin
      sum_d = sum_d + ACC_WIDTH'(prod_q[k]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q      <= '0;
      valid_s2_q <= 1'b0;
    end else begin
      valid_s2_q <= valid_s1_q;
      if (valid_s1_q) begin
        acc_q <= sum_d;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // S3: round / shift / saturate, output register and frame counter.
  // ---------------------------------------------------------------------------
  logic signed [DATA_WIDTH-1:0] sat_res;
  logic [PIX_CNT_WIDTH-1:0]     pix_cnt_q;

  conv_sat_round #(
    .DATA_WIDTH (DATA_WIDTH),
    .FRAC_BITS  (FRAC_BITS),
    .ACC_WIDTH  (ACC_WIDTH)
  ) u_sat_round (
    .acc_in  (acc_q),
    .res_out (sat_res)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_out   <= '0;
      result_valid <= 1'b0;
    end else begin
      result_valid <= valid_s2_q;
      if (valid_s2_q) begin
        result_out <= sat_res;
      end
    end
  end

  // A reload abandons the current frame; results still in flight after it
  // count towards the new frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_cnt_q  <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (load_start) begin
        pix_cnt_q <= '0;
      end else if (valid_s2_q) begin
        if (pix_cnt_q == LAST_PIX) begin
          pix_cnt_q  <= '0;
          frame_done <= 1'b1;
        end else begin
          pix_cnt_q <= pix_cnt_q + PIX_CNT_WIDTH'(1);
        end
      end
    end
  end

endmodule
